// File: rtl/rom_boot_loader.sv
// Turns the HPS ROM download byte stream into paced SDRAM boot writes, one byte per ce_ref window.
// Latency 1-16 clk from ioctl_wr to boot_wr; the HPS is held off via ioctl_wait for 17-32 clk per byte.
module rom_boot_loader #(
    parameter logic [8:0] PG_OS     = 9'h000,
    parameter logic [8:0] PG_BASIC  = 9'h100,
    parameter logic [8:0] PG_AMSDOS = 9'h107,
    parameter logic [8:0] PG_MF2    = 9'h1ff
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce_ref,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        rom_download,
    output logic        boot_wr,
    output logic [22:0] boot_a,
    output logic [1:0]  boot_bank,
    output logic [7:0]  boot_dout,
    output logic [7:0]  loaded_mask,
    output logic        err_range,
    output logic        err_proto
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_wait;
    logic        r_boot_wr;
    logic [22:0] r_boot_a;
    logic [1:0]  r_boot_bank;
    logic [7:0]  r_boot_dout;
    logic [2:0]  r_slot;
    logic [7:0]  r_loaded;
    logic        r_err_range;
    logic        r_err_proto;
    logic        r_dl_prev;

    logic [10:0] w_slot;
    logic        w_in_range;
    logic        w_dl_rise;
    logic        w_take;
    logic [8:0]  w_page;

    assign rom_download = ioctl_download & (ioctl_index == 8'd0);
    assign w_slot       = ioctl_addr[24:14];
    assign w_in_range   = (w_slot[10:3] == 8'd0);
    assign w_dl_rise    = rom_download & ~r_dl_prev;
    assign w_take       = ioctl_wr & rom_download;

    always_comb begin
        w_page = PG_OS;
        case (w_slot[1:0])
            2'd0: w_page = PG_OS;
            2'd1: w_page = PG_BASIC;
            2'd2: w_page = PG_AMSDOS;
            2'd3: w_page = PG_MF2;
            default: w_page = PG_OS;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_wait      <= 1'b0;
            r_boot_wr   <= 1'b0;
            r_boot_a    <= '0;
            r_boot_bank <= '0;
            r_boot_dout <= '0;
            r_slot      <= '0;
            r_loaded    <= '0;
            r_err_range <= 1'b0;
            r_err_proto <= 1'b0;
            r_dl_prev   <= 1'b0;
        end else begin
            r_dl_prev <= rom_download;

            // A new download clears the status; any event in the same cycle still lands on top.
            if (w_dl_rise) begin
                r_loaded    <= '0;
                r_err_range <= 1'b0;
                r_err_proto <= 1'b0;
            end

            if (w_take && (r_state != S_IDLE))
                r_err_proto <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        if (w_in_range) begin
                            r_boot_a    <= {w_page, ioctl_addr[13:0]};
                            r_boot_bank <= {1'b0, w_slot[2]};
                            r_boot_dout <= ioctl_dout;
                            r_slot      <= w_slot[2:0];
                            r_wait      <= 1'b1;
                            r_state     <= S_ARM;
                        end else begin
                            r_err_range <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (ce_ref) begin
                        r_boot_wr <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // The write occupies one full ce_ref period, closing on the next strobe.
                    if (ce_ref) begin
                        r_boot_wr <= 1'b0;
                        r_wait    <= 1'b0;
                        r_state   <= S_IDLE;
                        if (r_boot_a[13:0] == 14'h3FFF)
                            r_loaded[r_slot] <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ioctl_wait  = r_wait;
    assign boot_wr     = r_boot_wr;
    assign boot_a      = r_boot_a;
    assign boot_bank   = r_boot_bank;
    assign boot_dout   = r_boot_dout;
    assign loaded_mask = r_loaded;
    assign err_range   = r_err_range;
    assign err_proto   = r_err_proto;

endmodule

// File: tb/tb_rom_boot_loader.sv
// Bench for rom_boot_loader: directed corner cases plus random byte traffic against a transaction-level model.
module tb_rom_boot_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_ref = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait, rom_download, boot_wr, err_range, err_proto;
    logic [22:0] boot_a;
    logic [1:0]  boot_bank;
    logic [7:0]  boot_dout, loaded_mask;

    int total = 0;
    int bad = 0;
    logic [3:0] ce_cnt = 4'd0;

    logic [7:0] m_mask = '0;
    bit         m_erange = 1'b0;
    bit         m_eproto = 1'b0;

    rom_boot_loader dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_ref(ce_ref),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .rom_download(rom_download), .boot_wr(boot_wr),
        .boot_a(boot_a), .boot_bank(boot_bank), .boot_dout(boot_dout),
        .loaded_mask(loaded_mask), .err_range(err_range), .err_proto(err_proto)
    );

    always #5 clk_sys = ~clk_sys;

    // ce_ref is high for the posedge following every 16th negedge.
    always @(negedge clk_sys) begin
        ce_cnt = ce_cnt + 4'd1;
        ce_ref = (ce_cnt == 4'd15);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk_sys);
        #1;
    endtask

    function automatic logic [8:0] page_of(input int s);
        case (s % 4)
            0: return 9'h000;
            1: return 9'h100;
            2: return 9'h107;
            default: return 9'h1ff;
        endcase
    endfunction

    task automatic chk_status(input string tag);
        chk({tag, "_mask"}, loaded_mask, m_mask);
        chk({tag, "_erange"}, err_range, m_erange);
        chk({tag, "_eproto"}, err_proto, m_eproto);
    endtask

    // Caller is positioned just after a negedge; intr>0 injects a second write intr clk after the first.
    task automatic do_byte(input logic [24:0] a, input logic [7:0] d, input int intr, input string tag);
        int slot, k, first, wr_hi, wait_hi, it;
        bit rom, acc, stable;
        logic [22:0] exp_a;
        logic [1:0]  exp_bank;
        slot     = int'(a[24:14]);
        rom      = ioctl_download && (ioctl_index == 8'd0);
        acc      = rom && (slot < 8);
        exp_a    = {page_of(slot), a[13:0]};
        exp_bank = (slot >= 4) ? 2'd1 : 2'd0;
        k        = int'((4'd14 - ce_cnt) & 4'hF) + 1;
        it       = acc ? ((intr > k) ? k : intr) : 0;
        first = -1; wr_hi = 0; wait_hi = 0; stable = 1'b1;
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        tick;
        ioctl_wr = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (ioctl_wait) wait_hi++;
            if (boot_wr) begin
                if (first < 0) first = n;
                wr_hi++;
                if (boot_a !== exp_a || boot_bank !== exp_bank || boot_dout !== d) stable = 1'b0;
            end
            if (it > 0 && n + 1 == it) begin
                ioctl_wr = 1'b1;
                ioctl_addr = ~a;
                ioctl_dout = ~d;
            end else begin
                ioctl_wr = 1'b0;
            end
            tick;
        end
        if (acc) begin
            chk({tag, "_lat"}, first, k);
            chk({tag, "_wrlen"}, wr_hi, 16);
            chk({tag, "_waitlen"}, wait_hi, k + 16);
            chk({tag, "_data"}, stable, 1);
            if (a[13:0] == 14'h3FFF) m_mask[slot] = 1'b1;
            if (it > 0) m_eproto = 1'b1;
        end else begin
            chk({tag, "_nowr"}, wr_hi, 0);
            chk({tag, "_nowait"}, wait_hi, 0);
            if (rom) m_erange = 1'b1;
        end
        chk_status(tag);
    endtask

    task automatic restart_dl;
        ioctl_download = 1'b0;
        tick;
        ioctl_download = 1'b1;
        m_mask = '0; m_erange = 1'b0; m_eproto = 1'b0;
    endtask

    task automatic reset_mid_write;
        int guard;
        ioctl_wr = 1'b1; ioctl_addr = 25'h0C123; ioctl_dout = 8'h5A;
        tick;
        ioctl_wr = 1'b0;
        guard = 0;
        while (!boot_wr && guard < 40) begin
            tick;
            guard++;
        end
        chk("rst_reach_write", boot_wr, 1);
        chk("rst_write_a", boot_a, {9'h1ff, 14'h0123});
        tick; tick; tick;
        reset_n = 1'b0;
        #1;
        chk("rst_async_wr", boot_wr, 0);
        chk("rst_async_wait", ioctl_wait, 0);
        chk("rst_async_a", boot_a, 0);
        m_mask = '0; m_erange = 1'b0; m_eproto = 1'b0;
        chk_status("rst_async");
        tick; tick;
        reset_n = 1'b1;
        tick;
        do_byte(25'h0BFFF, 8'hC3, 0, "post_rst");
    endtask

    initial begin
        int s, intr;
        logic [13:0] off;
        tick; tick;
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_bootwr", boot_wr, 0);
        chk("rst_a", boot_a, 0);
        chk("rst_bank", boot_bank, 0);
        chk("rst_dout", boot_dout, 0);
        chk_status("rst");
        reset_n = 1'b1;
        tick;
        ioctl_download = 1'b1;
        #1;
        chk("romdl_on", rom_download, 1);
        tick;

        do_byte(25'h00005, 8'hA5, 0, "t1");
        chk("t1_a", boot_a, 23'h000005);
        do_byte(25'h17FFF, 8'h3C, 0, "t2");
        chk("t2_a", boot_a, 23'h403FFF);
        chk("t2_bank", boot_bank, 1);
        chk("t2_mask", loaded_mask, 8'h20);
        do_byte(25'h20000, 8'h77, 0, "t3");
        do_byte(25'h01234, 8'h11, 3, "t4");

        for (int i = 0; i < 16 && ce_cnt != 4'd15; i++) tick;
        chk("t5_phase", ce_cnt, 4'd15);
        do_byte(25'h0A000, 8'h96, 0, "t5");

        ioctl_index = 8'd1;
        #1;
        chk("romdl_off", rom_download, 0);
        do_byte(25'h03FFF, 8'h42, 0, "nonrom");
        ioctl_index = 8'd0;

        restart_dl;
        tick;
        chk_status("restart");

        restart_dl;
        do_byte(25'h1BFFF, 8'hE7, 0, "rise_wr");

        for (int i = 0; i < 40; i++) begin
            s    = $urandom_range(0, 9);
            off  = ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom);
            intr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
            repeat ($urandom_range(0, 5)) tick;
            if (i == 20) restart_dl;
            do_byte({11'(s), off}, 8'($urandom), intr, "rnd");
        end

        reset_mid_write;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
